// File: rtl/fun_pkg.sv
// fun_pkg: shared widths and dispatcher FSM state encoding for the fun datapath
package fun_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: operand-pair FIFO, DEPTH entries (power of 2), async active-low reset rst
// ports: clk, rst, push/wdata (write), pop/rdata (head), full, empty
module op_fifo
  import fun_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * OP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr, rd;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  // pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(wr) - (AW + 1)'(rd);
    end
endmodule

// File: rtl/fun_dispatch.sv
// fun_dispatch: buffers operand pairs, issues one fun op at a time, returns results in order
// ports: clk, rst (async active-low), in_valid/in_ready/in_a/in_b (operand stream),
//        out_valid/out_ready/out_data (result stream), fun_start/fun_a/fun_b/fun_busy/fun_result
//        (fun datapath), done_cnt (completed ops, only with FUN_DISPATCH_STATS_EN defined)
module fun_dispatch
  import fun_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             fun_start,
  output logic [OP_W-1:0]  fun_a,
  output logic [OP_W-1:0]  fun_b,
  input  logic             fun_busy,
  input  logic [RES_W-1:0] fun_result
`ifdef FUN_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("fun_dispatch: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end
  state_t state;
  logic [2*OP_W-1:0] head;
  logic full, empty, pop;
  assign in_ready = !full;
  assign pop      = state == IDLE && !empty;
  op_fifo #(.DEPTH(DEPTH), .W(2 * OP_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid && in_ready),
    .wdata({in_a, in_b}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      fun_start <= 1'b0;
      fun_a     <= '0;
      fun_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE:
          if (!empty) begin
            {fun_a, fun_b} <= head;
            fun_start      <= 1'b1;
            state          <= ISSUE;
          end
        ISSUE: begin
          fun_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT:
          if (!fun_busy) begin
            out_data  <= fun_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef FUN_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fun_dispatch.sv
// tb_fun_dispatch: randomized + directed self-checking bench for fun_dispatch with a behavioural fun
module tb_fun_dispatch;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, fun_start, fun_busy;
  logic [10:0] out_data, fun_result;
  logic [7:0] fun_a, fun_b;
`ifdef FUN_DISPATCH_STATS_EN
  logic [15:0] done_cnt;
`endif

  fun_dispatch #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fun_start(fun_start), .fun_a(fun_a), .fun_b(fun_b),
    .fun_busy(fun_busy), .fun_result(fun_result)
`ifdef FUN_DISPATCH_STATS_EN
    , .done_cnt(done_cnt)
`endif
  );

  function automatic int cbrt(int b);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction
  function automatic int ref_fun(int a, int b);
    return a * cbrt(b);
  endfunction

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // behavioural fun: busy for 1..4 cycles after a start, result valid when busy drops
  int lat_fix = -1;
  int fcnt;
  logic fbusy;
  logic [10:0] fres;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      fbusy <= 0;
      fres  <= 0;
      fcnt  <= 0;
    end else if (fun_start) begin
      fbusy <= 1;
      fres  <= 11'(ref_fun(fun_a, fun_b));
      fcnt  <= (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end else if (fbusy) begin
      if (fcnt == 0) fbusy <= 0;
      else fcnt <= fcnt - 1;
    end
  assign fun_busy   = fbusy;
  assign fun_result = fres;

  // scoreboard and per-cycle compare
  logic [15:0] op_q[$];
  int res_q[$];
  int got[$];
  int n_start = 0, hs = 0;
  logic prev_ov = 0, prev_taken = 0, prev_start = 0, busy_d1 = 0, busy_d2 = 0;
  logic [10:0] prev_data = 0;
  always @(negedge clk) begin
    if (!rst) begin
      op_q.delete();
      res_q.delete();
      got.delete();
      hs = 0;
      prev_ov = 0; prev_taken = 0; prev_start = 0; busy_d1 = 0; busy_d2 = 0;
    end else begin
      if (in_valid && in_ready) begin
        op_q.push_back({in_a, in_b});
        res_q.push_back(ref_fun(in_a, in_b));
      end
      if (fun_start) begin
        n_start++;
        chk("start_twice", prev_start, 0);
        chk("start_while_held", out_valid, 0);
        if (op_q.size() == 0) chk("start_without_push", 1, 0);
        else chk("fun_ab", int'({fun_a, fun_b}), int'(op_q.pop_front()));
      end
      if (prev_ov && !prev_taken) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !prev_ov) chk("valid_latency", int'({busy_d1, busy_d2}), 1);
`ifdef FUN_DISPATCH_STATS_EN
      chk("done_cnt", done_cnt, hs % 65536);
`endif
      if (out_valid) begin
        if (res_q.size() == 0) chk("valid_without_push", 1, 0);
        else chk("out_data", out_data, res_q[0]);
        if (out_ready) begin
          got.push_back(out_data);
          if (res_q.size() != 0) void'(res_q.pop_front());
          hs++;
        end
      end
      prev_ov = out_valid;
      prev_taken = out_valid && out_ready;
      prev_data = out_data;
      prev_start = fun_start;
      busy_d2 = busy_d1;
      busy_d1 = fun_busy;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic try_push(input int a, input int b, output bit acc);
    in_valid = 1; in_a = 8'(a); in_b = 8'(b);
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic push(input int a, input int b);
    bit acc = 0;
    for (int i = 0; i < 200 && !acc; i++) try_push(a, b, acc);
    if (!acc) chk("push_timeout", 0, 1);
  endtask
  task automatic wait_got(input int n);
    for (int i = 0; i < 300 && got.size() < n; i++) tick();
    chk("result_count", got.size(), n);
  endtask
  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    #2 rst = 1;
    tick();
  endtask

  int vals[3][3] = '{'{255, 255, 1530}, '{0, 200, 0}, '{10, 0, 0}};
  initial begin
    int s0, nacc;
    bit acc;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fun_start", fun_start, 0);
    chk("rst_fun_a", fun_a, 0);
    chk("rst_fun_b", fun_b, 0);
`ifdef FUN_DISPATCH_STATS_EN
    chk("rst_done_cnt", done_cnt, 0);
`endif
    #1 rst = 1;
    tick(2);

    out_ready = 1;
    got.delete();
    push(5, 27);
    @(negedge clk);
    chk("start_early", fun_start, 0);
    @(negedge clk);
    chk("start_latency", fun_start, 1);
    tick();
    wait_got(1);
    if (got.size() > 0) chk("single_15", got[0], 15);
    tick(3);
    chk("idle_out_valid", out_valid, 0);
    chk("single_one_start", n_start, 1);

    for (int k = 0; k < 3; k++) begin
      got.delete();
      push(vals[k][0], vals[k][1]);
      wait_got(1);
      if (got.size() > 0) chk("boundary", got[0], vals[k][2]);
    end
    tick(3);

    out_ready = 0;
    got.delete();
    s0 = n_start;
    push(10, 8); push(3, 64); push(7, 1);
    tick(20);
    chk("bp_one_start", n_start - s0, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 20);
    out_ready = 1;
    wait_got(3);
    if (got.size() >= 3) begin
      chk("order_0", got[0], 20);
      chk("order_1", got[1], 12);
      chk("order_2", got[2], 7);
    end
    tick(3);

    out_ready = 0;
    got.delete();
    nacc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      try_push(i + 1, 27, acc);
      nacc += int'(acc);
    end
    chk("full_accepted", nacc, DEPTH + 1);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1;
    wait_got(DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < got.size(); i++) chk("full_drain", got[i], 3 * (i + 1));
    tick(3);

    lat_fix = 6;
    push(1, 1);
    for (int i = 0; i < 50 && !fun_busy; i++) tick();
    chk("reach_wait", fun_busy, 1);
    rst = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_fun_start", fun_start, 0);
    @(negedge clk);
    #2 rst = 1;
    lat_fix = -1;
    tick();
    got.delete();
    push(2, 125);
    wait_got(1);
    if (got.size() > 0) chk("after_rst_10", got[0], 10);
    tick(3);

`ifdef FUN_DISPATCH_STATS_EN
    do_reset();
    chk("stats_zero", done_cnt, 0);
    for (int i = 0; i < 5; i++) push(i, 64);
    wait_got(5);
    tick(2);
    chk("stats_five", done_cnt, 5);
    do_reset();
    chk("stats_reset", done_cnt, 0);
`endif

    for (int c = 0; c < 600; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) != 0) try_push($urandom_range(0, 255), $urandom_range(0, 255), acc);
      else tick();
    end
    out_ready = 1;
    for (int i = 0; i < 500 && (res_q.size() != 0 || out_valid); i++) tick();
    chk("random_drained", res_q.size(), 0);
    chk("random_issue_q", op_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fun_dispatch.md
Name: fun_dispatch

Overview:
- Upstream feeder and result collector for the `fun` datapath, which computes result = a * cbrt(b) over 8-bit operands with an 11-bit result.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Launches one `fun` operation at a time using the start/busy protocol.
- Returns each result on a valid/ready output stream, in order.

Parameters:
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the completion counter (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept a pair
- in_a  in  8  operand a
- in_b  in  8  operand b
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- out_data  out  11  a*cbrt(b)
- fun_start  out  1  start pulse to fun
- fun_a  out  8  operand a to fun
- fun_b  out  8  operand b to fun
- fun_busy  in  1  busy from fun
- fun_result  in  11  result from fun
- done_cnt  out  CNT_W  completed operations (only with STATS feature)

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, in_ready=1, out_valid=0, out_data=0, fun_start=0, fun_a=fun_b=0, done_cnt=0.
- The integrator drives fun's active-high reset from ~rst.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (count < DEPTH), registered count, no combinational path from in_valid.
  - Pop occurs only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle leave count unchanged; the pointers wrap modulo DEPTH.
  - Push while full is ignored (in_ready=0).
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if count>0, pop the head into the fun_a/fun_b registers and go to ISSUE. Otherwise stay.
  - ISSUE: fun_start=1 for exactly one cycle, with fun_a/fun_b stable. Go to WAIT.
  - WAIT: fun_busy is 1 on the first WAIT cycle. When fun_busy==0 (on the first WAIT cycle or later), capture out_data<=fun_result, set out_valid<=1, and go to HOLD.
  - HOLD: out_valid=1 and out_data stable until out_ready. On out_valid && out_ready, set out_valid<=0 and go to IDLE.
- fun_a/fun_b hold their values from pop until the next pop.
- fun_start is asserted only in ISSUE; no new operation is issued while a result is held.
- Latency:
  - Push into an empty FIFO with the FSM in IDLE: fun_start asserts 2 cycles after the push edge.
  - out_valid rises 1 cycle after fun_busy falls.
- Ordering: results appear strictly in push order.
- Width rule: out_data = fun_result unmodified (the maximum 255*6=1530 fits in 11 bits).
- Mid-operation reset: the FIFO contents and any held result are discarded. fun is reset by the same source, so no stale result is captured.
- in_ready stays independent of out_ready: the FIFO keeps filling while HOLD stalls.

Optional Feature:
- Macro FUN_DISPATCH_STATS_EN.
- Defined: done_cnt increments by 1 on each out_valid && out_ready handshake, wraps at 2^CNT_W, and resets to 0.
- Undefined: the done_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package fun_pkg: OP_W=8, RES_W=11, state enum (IDLE, ISSUE, WAIT, HOLD).
- Sub-module op_fifo (parameter DEPTH, data width 2*OP_W): push/pop/count/full/empty, async active-low reset.
- The FSM and result register live in fun_dispatch.

Test Plan:
- Single op: push (a=5, b=27) with out_ready=1 -> one fun_start pulse 2 cycles after push, out_data=15, then the FSM returns to IDLE.
- Boundary values:
  - Push (255,255) -> out_data=1530.
  - Push (0,200) -> 0.
  - Push (10,0) -> 0.
- Backpressure and order: push (10,8), (3,64), (7,1) back-to-back with out_ready=0 for 20 cycles -> only one fun_start issued, out_data=20 held stable. Then out_ready=1 -> results 20, 12, 7 in order.
- FIFO full: with out_ready=0, push DEPTH+2 pairs -> in_ready drops after the FIFO fills; the extra pushes are not accepted and no data is lost.
- Mid-operation reset: pull rst low during WAIT -> out_valid=0 and in_ready=1 immediately; after release, a push of (2,125) -> out_data=10.
- STATS_EN: complete 5 ops -> done_cnt=5. Reset -> 0.
